// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide on operand magnitudes, with a registered, sign-corrected result.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0]   ZERO_X = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   ONES_X = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]     CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0]     CNT_ZERO = {CW{1'b0}};

  function automatic logic [XLEN-1:0] neg_if(input logic en, input logic [XLEN-1:0] v);
    return en ? (~v + ONE_X) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if2(input logic en, input logic [2*XLEN-1:0] v);
    return en ? (~v + ONE_2X) : v;
  endfunction

  // hi_q: product high half / partial remainder; lo_q: multiplier / dividend-quotient
  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            dbz_q, dbz_d;

  logic            a_signed_s, b_signed_s, is_div_s;
  logic            a_neg_s, b_neg_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s;
  logic            b_zero_s, ovf_s, fast_s;
  logic [XLEN-1:0] fast_res_s;
  logic            neg_new_s;

  // Operand decode for the accepting edge: signedness, magnitudes and fast paths
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    neg_new_s  = 1'b0;
    is_div_s   = op[2];
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      OP_MULHSU: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      OP_MULHU, OP_DIVU, OP_REMU: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
    a_neg_s  = a_signed_s & A[XLEN-1];
    b_neg_s  = b_signed_s & B[XLEN-1];
    a_mag_s  = neg_if(a_neg_s, A);
    b_mag_s  = neg_if(b_neg_s, B);
    b_zero_s = is_div_s & (B == ZERO_X);
    ovf_s    = is_div_s & ~op[0] & (A == MIN_X) & (B == ONES_X);
    fast_s   = b_zero_s | ovf_s;
    // Remainder follows the dividend's sign; products and quotients follow the sign XOR
    if (is_div_s && op[1]) begin
      neg_new_s = a_neg_s;
    end else begin
      neg_new_s = a_neg_s ^ b_neg_s;
    end
    if (b_zero_s) begin
      fast_res_s = op[1] ? A : ONES_X;
    end else if (ovf_s) begin
      fast_res_s = op[1] ? ZERO_X : MIN_X;
    end else begin
      fast_res_s = ZERO_X;
    end
  end

  logic [XLEN:0]     mul_sum_s;
  logic [XLEN-1:0]   mul_hi_n_s, mul_lo_n_s;
  logic [XLEN:0]     div_part_s, div_diff_s;
  logic              div_ge_s;
  logic [XLEN-1:0]   div_hi_n_s, div_lo_n_s;
  logic [XLEN-1:0]   step_hi_s, step_lo_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   final_res_s;

  // One iteration of shift-add multiply or restoring divide, plus final sign fix-up
  always_comb begin
    mul_sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_hi_n_s = mul_sum_s[XLEN:1];
    mul_lo_n_s = {mul_sum_s[0], lo_q[XLEN-1:1]};
    div_part_s = {hi_q, lo_q[XLEN-1]};
    div_ge_s   = (div_part_s >= {1'b0, opnd_q});
    div_diff_s = div_part_s - {1'b0, opnd_q};
    if (div_ge_s) begin
      div_hi_n_s = div_diff_s[XLEN-1:0];
    end else begin
      div_hi_n_s = div_part_s[XLEN-1:0];
    end
    div_lo_n_s = {lo_q[XLEN-2:0], div_ge_s};
    if (op_q[2]) begin
      step_hi_s = div_hi_n_s;
      step_lo_s = div_lo_n_s;
    end else begin
      step_hi_s = mul_hi_n_s;
      step_lo_s = mul_lo_n_s;
    end
    prod_fix_s = neg_if2(neg_q, {mul_hi_n_s, mul_lo_n_s});
    if (op_q[2]) begin
      final_res_s = op_q[1] ? neg_if(neg_q, div_hi_n_s) : neg_if(neg_q, div_lo_n_s);
    end else if (op_q[1:0] == 2'b00) begin
      final_res_s = prod_fix_s[XLEN-1:0];
    end else begin
      final_res_s = prod_fix_s[2*XLEN-1:XLEN];
    end
  end

  // Control FSM and datapath next-state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_d    = neg_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_CALC: begin
        hi_d = step_hi_s;
        lo_d = step_lo_s;
        if (cnt_q == CNT_LAST) begin
          state_d  = S_FIN;
          cnt_d    = CNT_ZERO;
          done_d   = 1'b1;
          result_d = final_res_s;
          dbz_d    = 1'b0;
        end else begin
          state_d = S_CALC;
          cnt_d   = cnt_q + CW'(1);
          busy_d  = 1'b1;
        end
      end
      S_IDLE, S_FIN: begin
        if (start) begin
          op_d   = op;
          neg_d  = neg_new_s;
          hi_d   = ZERO_X;
          cnt_d  = CNT_ZERO;
          opnd_d = is_div_s ? b_mag_s : a_mag_s;
          lo_d   = is_div_s ? a_mag_s : b_mag_s;
          if (fast_s) begin
            state_d  = S_FIN;
            done_d   = 1'b1;
            result_d = fast_res_s;
            dbz_d    = b_zero_s;
          end else begin
            state_d = S_CALC;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      hi_q     <= ZERO_X;
      lo_q     <= ZERO_X;
      opnd_q   <= ZERO_X;
      op_q     <= 3'b000;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= ZERO_X;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit arithmetic
  task automatic ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic dbz, output int lat);
    int          sa, sb;
    logic [63:0] p;
    sa  = a;
    sb  = b;
    dbz = 1'b0;
    lat = 33;
    res = 32'h0;
    case (o)
      3'b000: begin p = 64'(longint'(sa) * longint'(sb)); res = p[31:0]; end
      3'b001: begin p = 64'(longint'(sa) * longint'(sb)); res = p[63:32]; end
      3'b010: begin p = 64'(longint'(sa) * longint'({32'h0, b})); res = p[63:32]; end
      3'b011: begin p = {32'h0, a} * {32'h0, b}; res = p[63:32]; end
      default: begin
        if (b == 32'h0) begin
          dbz = 1'b1;
          lat = 1;
          res = o[1] ? a : 32'hFFFF_FFFF;
        end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lat = 1;
          res = o[1] ? 32'h0 : 32'h8000_0000;
        end else begin
          case (o[1:0])
            2'b00:   res = 32'(sa / sb);
            2'b01:   res = a / b;
            2'b10:   res = 32'(sa % sb);
            default: res = a % b;
          endcase
        end
      end
    endcase
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    A     = a;
    B     = b;
    start = 1'b1;
  endtask

  // Called mid-cycle with start already raised; returns mid-cycle in the done cycle
  task automatic run_wait(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int poke);
    logic [31:0] er;
    logic        ed;
    int          el;
    int          k;
    bit          saw_busy;
    ref_model(o, a, b, er, ed, el);
    @(posedge clk);
    #1;
    start    = 1'b0;
    k        = 1;
    saw_busy = 1'b0;
    while (!done && k < 100) begin
      if (busy) saw_busy = 1'b1;
      if (k == poke) begin
        op    = 3'($urandom_range(0, 7));
        A     = $urandom;
        B     = $urandom;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    check_eq({tag, "_lat"}, 64'(k), 64'(el));
    check_eq({tag, "_res"}, 64'(result), 64'(er));
    check_eq({tag, "_dbz"}, 64'(div_by_zero), 64'(ed));
    check_eq({tag, "_busy_done"}, 64'(busy), 64'h0);
    check_eq({tag, "_busy_seen"}, 64'(saw_busy), 64'(el > 1));
  endtask

  task automatic single(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    issue(o, a, b);
    run_wait(tag, o, a, b, 0);
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse"}, 64'(done), 64'h0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          dones;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'b000;
    A     = 32'h0;
    B     = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'h0);
    check_eq("rst_done", 64'(done), 64'h0);
    check_eq("rst_result", 64'(result), 64'h0);
    check_eq("rst_dbz", 64'(div_by_zero), 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    single("mul", 3'b000, 32'd7, 32'hFFFF_FFFD);
    single("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000);
    single("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    single("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    single("div", 3'b100, 32'hFFFF_FFEC, 32'd3);
    single("rem", 3'b110, 32'hFFFF_FFEC, 32'd3);
    single("divu", 3'b101, 32'd20, 32'd3);
    single("remu", 3'b111, 32'd20, 32'd3);
    single("div0", 3'b100, 32'd100, 32'd0);
    single("remu0", 3'b111, 32'd100, 32'd0);
    single("ovf_div", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    single("ovf_rem", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    single("mul_zero", 3'b000, 32'h1234_5678, 32'h0);

    issue(3'b000, 32'd7, 32'hFFFF_FFFD);
    run_wait("ignore", 3'b000, 32'd7, 32'hFFFF_FFFD, 5);

    // Back-to-back: new request raised during the done cycle
    issue(3'b101, 32'd1000, 32'd7);
    run_wait("b2b_first", 3'b101, 32'd1000, 32'd7, 0);
    issue(3'b011, 32'hDEAD_BEEF, 32'h1234_5678);
    run_wait("b2b_second", 3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    issue(3'b100, 32'd5, 32'd0);
    run_wait("b2b_fast", 3'b100, 32'd5, 32'd0, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
        3:       ra = 32'($urandom_range(0, 100));
        default: ;
      endcase
      issue(ro, ra, rb);
      run_wait($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, 0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end

    single("pre_rst", 3'b101, 32'd20, 32'd3);
    issue(3'b101, 32'd1000, 32'd7);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(busy), 64'h0);
    check_eq("midrst_done", 64'(done), 64'h0);
    check_eq("midrst_result", 64'(result), 64'h0);
    check_eq("midrst_dbz", 64'(div_by_zero), 64'h0);
    dones = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check_eq("midrst_no_done", 64'(dones), 64'h0);
    single("post_rst", 3'b101, 32'd9, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
